angle_lut_sched: RTL and testbench
==================================

# angle_lut_sched

Round-robin scheduler that shares one `output_lut` index-to-angle table between `NREQ` requesters. It accepts a bin index from one requester at a time and drives the LUT's `din`/`ena` pins. It captures the registered 9-bit angle (0..180 degrees) and presents it with the requester ID on a valid/ready output port. It sits between the per-channel peak detectors and the angle reporting/output stage.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `NDATA`, 128, LUT depth; must match the `output_lut` instance
- `NDATA_LOG`, `$clog2(NDATA)`, index width
- `NREQ_LOG`, `$clog2(NREQ)`, requester ID width
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NREQ  per-requester index valid
- `req_index`  in  NREQ*NDATA_LOG  packed indices; requester i uses bits [i*NDATA_LOG +: NDATA_LOG]
- `req_ready`  out  NREQ  one-hot accept strobe
- `lut_din`  out  NDATA_LOG  index to LUT
- `lut_ena`  out  1  LUT enable, active-low (0 = load)
- `lut_dout`  in  9  registered LUT angle
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `out_angle`  out  9  angle, degrees
- `out_id`  out  NREQ_LOG  requester that produced `out_angle`
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, LOOKUP, CAPTURE, OUTPUT.
- **IDLE:** if any `req_valid` is high, the round-robin picks grant g, searching upward from pointer `ptr` with wrap. The block then:
  - asserts `req_ready[g]` for that cycle only;
  - latches `req_index[g]` and g;
  - sets `ptr` to (g+1) mod NREQ;
  - moves to LOOKUP.
- **LOOKUP:** `lut_din` = latched index, `lut_ena` = 0 for exactly this cycle. Go to CAPTURE.
- **CAPTURE:** `lut_ena` = 1. Register `lut_dout` into `out_angle` and g into `out_id`. Go to OUTPUT with `out_valid` = 1.
- **OUTPUT:** `out_valid`, `out_angle` and `out_id` stay stable until `out_ready` = 1. On that handshake:
  - if any `req_valid` is high, arbitrate and accept in the same cycle exactly as in IDLE, then go straight to LOOKUP;
  - otherwise go to IDLE with `out_valid` = 0.
- `req_ready` is never asserted outside IDLE or an OUTPUT handshake cycle. At most one `req_ready` bit is high in any cycle.
- `lut_ena` = 1 in every state except LOOKUP, so the LUT output register holds its value.
- Indices are not range-checked; all 2^NDATA_LOG values are legal.

## Timing
- Reset values:
  - `req_ready` = 0, `lut_din` = 0, `lut_ena` = 1;
  - `out_valid` = 0, `out_angle` = 0, `out_id` = 0, `busy` = 0;
  - `ptr` = 0, state IDLE.
- Accept at cycle T produces LOOKUP at T+1, CAPTURE at T+2, and `out_valid` high at T+3.
- Sustained throughput with `out_ready` = 1: one result every 3 cycles.
- A `req_valid` drop without `req_ready` is allowed. A requester that is not granted keeps its request pending.
- Reset asserted in any state: the next cycle shows reset values. An in-flight request that was already accepted is discarded with no output.
- Reset and `out_ready` in the same cycle: reset wins.

## Configuration
- Macro: `ANGLE_CHANGE_EN`.
- **Defined:** the block keeps a per-requester last-emitted angle register, reset to 9'h1FF (no value emitted yet).
  - In CAPTURE, if `lut_dout` equals last[g], the result is dropped: go to IDLE with `out_valid` = 0 and no output.
  - Otherwise emit the result and update last[g] in the same cycle.
- **Undefined:** every accepted request yields exactly one output, and no per-requester storage exists.

## Structure
- Package `angle_pkg` holds:
  - `ANGLE_W` = 9, `ANGLE_NONE` = 9'h1FF;
  - the FSM state enum `sched_state_t`.
- Sub-module `rr_arbiter`: combinational round-robin over `NREQ` with inputs `req` and `ptr`, outputs one-hot `gnt` and encoded `gnt_id`. `ptr` is registered in the parent.
- `output_lut` is instantiated at the top level next to this block, not inside it.

## Test plan
- Requester 0 sends index 0 at T → `req_ready[0]` high at T, `out_valid` high at T+3, `out_angle` = 90, `out_id` = 0.
- Requester 2 sends index 65, then index 63 → outputs 180 then 0, both with `out_id` = 2.
- All 4 `req_valid` held high with `out_ready` = 1 → `out_id` sequence 0,1,2,3,0 with `out_valid` every 3rd cycle.
- `out_ready` held low for 5 cycles in OUTPUT → `out_valid`, `out_angle` and `out_id` stable, all `req_ready` = 0, `lut_ena` = 1.
- `rst` pulsed while in LOOKUP → next cycle all outputs at reset values; the following request from requester 3 wins only after requesters 0..2, i.e. `ptr` = 0.
- With `ANGLE_CHANGE_EN`, requester 1 sends index 5 then index 6 (both 85) → one output only. Without the macro, two outputs of 85.

Source files
------------

// File: rtl/angle_pkg.sv
// ============================================================================
// Module      : angle_pkg
// Description : Shared types and constants for the angle LUT scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package angle_pkg;

  localparam int ANGLE_W = 9;
  localparam logic [ANGLE_W-1:0] ANGLE_NONE = 9'h1FF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOOKUP  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_OUTPUT  = 2'd3
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter; searches upward from ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NREQ     = 4,
  parameter int NREQ_LOG = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ_LOG-1:0] ptr,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ_LOG-1:0] gnt_id
);

  int w_j;

  // Walk from farthest to nearest so the requester closest to ptr wins last.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    w_j    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = (int'(ptr) + k) % NREQ;
      if (req[w_j]) begin
        gnt      = '0;
        gnt[w_j] = 1'b1;
        gnt_id   = NREQ_LOG'(w_j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/angle_lut_sched.sv
// ============================================================================
// Module      : angle_lut_sched
// Description : Round-robin scheduler sharing one index-to-angle LUT between
//               NREQ requesters. Optional macro ANGLE_CHANGE_EN suppresses
//               results equal to the requester's last emitted angle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module angle_lut_sched
  import angle_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int NDATA     = 128,
  parameter int NDATA_LOG = $clog2(NDATA),
  parameter int NREQ_LOG  = $clog2(NREQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ*NDATA_LOG-1:0]   req_index,
  output logic [NREQ-1:0]             req_ready,
  output logic [NDATA_LOG-1:0]        lut_din,
  output logic                        lut_ena,
  input  logic [ANGLE_W-1:0]          lut_dout,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ANGLE_W-1:0]          out_angle,
  output logic [NREQ_LOG-1:0]         out_id,
  output logic                        busy
);

  sched_state_t           r_state;
  sched_state_t           w_next;
  logic [NREQ_LOG-1:0]    r_ptr;
  logic [NREQ_LOG-1:0]    w_ptr_next;
  logic [NREQ_LOG-1:0]    w_gnt_id;
  logic [NREQ_LOG-1:0]    r_gid;
  logic [NREQ-1:0]        w_gnt;
  logic [NDATA_LOG-1:0]   r_index;
  logic [ANGLE_W-1:0]     r_angle;
  logic [NREQ_LOG-1:0]    r_id;
  logic                   w_any;
  logic                   w_accept;
  logic                   w_emit;
  logic [NDATA_LOG-1:0]   w_idx [NREQ];

  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign w_idx[i] = req_index[i*NDATA_LOG +: NDATA_LOG];
    end
  endgenerate

  rr_arbiter #(
    .NREQ     (NREQ),
    .NREQ_LOG (NREQ_LOG)
  ) u_arb (
    .req    (req_valid),
    .ptr    (r_ptr),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id)
  );

  assign w_any      = |req_valid;
  assign w_ptr_next = (w_gnt_id == NREQ_LOG'(NREQ - 1)) ? '0 : w_gnt_id + NREQ_LOG'(1);

`ifdef ANGLE_CHANGE_EN
  logic [ANGLE_W-1:0] r_last [NREQ];

  // A repeat of the last emitted angle for this requester is dropped.
  assign w_emit = (lut_dout != r_last[r_gid]);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) r_last[i] <= ANGLE_NONE;
    end else if (r_state == ST_CAPTURE && w_emit) begin
      r_last[r_gid] <= lut_dout;
    end
  end
`else
  assign w_emit = 1'b1;
`endif

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_accept = 1'b1;
          w_next   = ST_LOOKUP;
        end
      end
      ST_LOOKUP:  w_next = ST_CAPTURE;
      ST_CAPTURE: w_next = w_emit ? ST_OUTPUT : ST_IDLE;
      ST_OUTPUT: begin
        if (out_ready) begin
          if (w_any) begin
            w_accept = 1'b1;
            w_next   = ST_LOOKUP;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_index <= '0;
      r_gid   <= '0;
      r_angle <= '0;
      r_id    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_index <= w_idx[w_gnt_id];
        r_gid   <= w_gnt_id;
        r_ptr   <= w_ptr_next;
      end
      if (r_state == ST_CAPTURE && w_emit) begin
        r_angle <= lut_dout;
        r_id    <= r_gid;
      end
    end
  end

  assign req_ready = w_accept ? w_gnt : '0;
  assign lut_din   = r_index;
  assign lut_ena   = (r_state != ST_LOOKUP);
  assign out_valid = (r_state == ST_OUTPUT);
  assign out_angle = r_angle;
  assign out_id    = r_id;
  assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_angle_lut_sched.sv
// ============================================================================
// Module      : tb_angle_lut_sched
// Description : Self-checking bench for angle_lut_sched with a transaction
//               timeline reference model and a behavioural LUT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_angle_lut_sched;
  import angle_pkg::*;

  localparam int NREQ      = 4;
  localparam int NDATA     = 128;
  localparam int NDATA_LOG = 7;
  localparam int NREQ_LOG  = 2;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ*NDATA_LOG-1:0] req_index;
  logic [NREQ-1:0]           req_ready;
  logic [NDATA_LOG-1:0]      lut_din;
  logic                      lut_ena;
  logic [8:0]                lut_dout;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic [8:0]                out_angle;
  logic [NREQ_LOG-1:0]       out_id;
  logic                      busy;

  logic [NREQ-1:0]           pend = '0;
  logic [NDATA_LOG-1:0]      pidx [NREQ];
  logic [NREQ-1:0]           seen_ready = '0;
  bit                        rnd_en = 1'b0;
  int                        n_checks = 0;
  int                        n_errs = 0;

  always #5 clk = ~clk;

  assign req_valid = rst ? '0 : pend;
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
      assign req_index[gi*NDATA_LOG +: NDATA_LOG] = pidx[gi];
    end
  endgenerate

  angle_lut_sched #(
    .NREQ(NREQ), .NDATA(NDATA), .NDATA_LOG(NDATA_LOG), .NREQ_LOG(NREQ_LOG)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_index(req_index),
    .req_ready(req_ready), .lut_din(lut_din), .lut_ena(lut_ena),
    .lut_dout(lut_dout), .out_valid(out_valid), .out_ready(out_ready),
    .out_angle(out_angle), .out_id(out_id), .busy(busy)
  );

  // Behavioural index-to-angle table with the known anchor points.
  function automatic logic [8:0] lut_fn(input logic [NDATA_LOG-1:0] idx);
    case (idx)
      7'd0:    return 9'd90;
      7'd5:    return 9'd85;
      7'd6:    return 9'd85;
      7'd63:   return 9'd0;
      7'd65:   return 9'd180;
      default: return 9'((int'(idx) * 7) % 181);
    endcase
  endfunction

  always @(posedge clk) if (!lut_ena) lut_dout <= lut_fn(lut_din);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight, aged in cycles since accept.
  bit                   m_init = 1'b0;
  bit                   m_infl = 1'b0;
  bit                   m_drop = 1'b0;
  int                   m_age = 0;
  int                   m_ptr = 0;
  logic [8:0]           m_ang_pend = '0;
  int                   m_id_pend = 0;
  logic [8:0]           m_out_ang = '0;
  int                   m_out_id = 0;
  logic [NDATA_LOG-1:0] m_idx = '0;
  logic [8:0]           m_last [NREQ];
  logic [NREQ-1:0]      e_ready;
  bit                   e_valid, e_ena, can_acc;
  int                   g;

  always @(negedge clk) begin
    seen_ready = req_ready;
    if (m_init) begin
      if (m_infl) begin
        m_age++;
        if (m_age == 3) begin
          if (m_drop) m_infl = 1'b0;
          else begin
            m_out_ang = m_ang_pend;
            m_out_id  = m_id_pend;
          end
        end
      end
      e_valid = m_infl && (m_age >= 3);
      e_ena   = !(m_infl && m_age == 1);
      can_acc = !m_infl || (e_valid && out_ready);
      g = -1;
      e_ready = '0;
      if (can_acc)
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      if (g >= 0) e_ready[g] = 1'b1;

      check_eq("out_valid", out_valid, e_valid);
      check_eq("busy", busy, m_infl);
      check_eq("lut_ena", lut_ena, e_ena);
      check_eq("req_ready", req_ready, e_ready);
      check_eq("out_angle", out_angle, m_out_ang);
      check_eq("out_id", out_id, m_out_id);
      if (!e_ena) check_eq("lut_din", lut_din, m_idx);

      if (e_valid && out_ready) m_infl = 1'b0;
      if (g >= 0) begin
        m_infl     = 1'b1;
        m_age      = 0;
        m_idx      = pidx[g];
        m_ang_pend = lut_fn(pidx[g]);
        m_id_pend  = g;
        m_ptr      = (g + 1) % NREQ;
`ifdef ANGLE_CHANGE_EN
        m_drop = (m_ang_pend == m_last[g]);
        if (!m_drop) m_last[g] = m_ang_pend;
`else
        m_drop = 1'b0;
`endif
      end
    end
    if (rst) begin
      m_init    = 1'b1;
      m_infl    = 1'b0;
      m_ptr     = 0;
      m_out_ang = '0;
      m_out_id  = 0;
      m_idx     = '0;
      for (int i = 0; i < NREQ; i++) m_last[i] = ANGLE_NONE;
    end
  end

  function automatic logic [NDATA_LOG-1:0] pick_idx();
    case ($urandom_range(0, 5))
      0:       return 7'd0;
      1:       return 7'd5;
      2:       return 7'd6;
      3:       return 7'd63;
      4:       return 7'd65;
      default: return NDATA_LOG'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    pend = pend & ~seen_ready;
    if (rnd_en) begin
      out_ready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            pend[i] = 1'b1;
            pidx[i] = pick_idx();
          end
        end else if ($urandom_range(0, 40) == 0) begin
          pend[i] = 1'b0;
        end
      end
      rst = ($urandom_range(0, 249) == 0);
    end
  endtask

  task automatic issue(input int i, input logic [NDATA_LOG-1:0] idx);
    pidx[i] = idx;
    pend[i] = 1'b1;
    for (int n = 0; n < 60 && pend[i]; n++) tick();
    check_eq("accept_timeout", pend[i], 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) pidx[i] = '0;
    rst = 1'b1;
    ticks(3);
    rst = 1'b0;
    check_eq("rst_lut_din", lut_din, 7'd0);
    out_ready = 1'b1;

    issue(0, 7'd0);
    ticks(6);

    issue(2, 7'd65);
    issue(2, 7'd63);
    ticks(6);

    for (int i = 0; i < NREQ; i++) pidx[i] = NDATA_LOG'(10 + i);
    for (int n = 0; n < 16; n++) begin
      pend = '1;
      tick();
    end
    pend = '0;
    ticks(8);

    issue(1, 7'd10);
    out_ready = 1'b0;
    pidx[0]   = 7'd11;
    pend[0]   = 1'b1;
    ticks(8);
    out_ready = 1'b1;
    ticks(8);

    issue(0, 7'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_out_angle", out_angle, 9'd0);
    check_eq("rst_lut_din", lut_din, 7'd0);
    for (int i = 0; i < NREQ; i++) pidx[i] = NDATA_LOG'(20 + i);
    pend = '1;
    ticks(14);

    issue(1, 7'd5);
    ticks(5);
    issue(1, 7'd6);
    ticks(6);

    rnd_en = 1'b1;
    ticks(2000);
    rnd_en    = 1'b0;
    rst       = 1'b0;
    pend      = '0;
    out_ready = 1'b1;
    ticks(10);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
